// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl_if
//  Purpose  : Write-side handshake bundle for seg_scan_ctrl. The producer
//             (state/pattern logic) offers a full set of digit nibbles with
//             wr_valid; the scanner answers with wr_ready.
//  Signals  : wr_valid  - new display contents offered (master -> slave)
//             wr_ready  - scanner can accept wr_data   (slave  -> master)
//             wr_data   - 4*NUM_DIGITS bits, digit i = wr_data[4i+3:4i]
//  Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [4*NUM_DIGITS-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a common-anode seven-segment
//             display. One digit per scan slot, each slot starting with a
//             blanking gap. New contents land in a pending register and are
//             applied only at frame boundaries so frames never tear.
//  Ports    : clk, rst_n (async, active-low), en (scan enable),
//             wr (seg_scan_ctrl_if.slave: wr_valid/wr_ready/wr_data),
//             digit_mask (per-digit enable, sampled live),
//             dim[3:0] (only with SEG_SCAN_DIM_EN),
//             AN (active-low anodes), SEG (active-low {g..a}),
//             frame_done (1-cycle pulse at the end of the last slot).
//  Options  : `define SEG_SCAN_DIM_EN adds the dim input; during DRIVE the
//             anode is then asserted only while
//             (slot_cnt - BLANK_CYCLES) mod 16 <= dim.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  en,
  seg_scan_ctrl_if.slave             wr,
  input  wire logic [NUM_DIGITS-1:0] digit_mask,
`ifdef SEG_SCAN_DIM_EN
  input  wire logic [3:0]            dim,
`endif
  output logic      [NUM_DIGITS-1:0] AN,
  output logic      [6:0]            SEG,
  output logic                       frame_done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0] C_SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] C_BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] C_IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [1:0]              state_q,      state_d;
  logic [IW-1:0]           idx_q,        idx_d;
  logic [SW-1:0]           slot_cnt_q,   slot_cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q,     active_d;
  logic [4*NUM_DIGITS-1:0] pending_q,    pending_d;
  logic                    pending_vld_q, pending_vld_d;
  logic [NUM_DIGITS-1:0]   an_q,         an_d;
  logic [6:0]              seg_q,        seg_d;
  logic                    frame_done_q, frame_done_d;

  logic                    w_xfer;
  logic [3:0]              w_nib;
  logic                    w_dim_on;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // The pending register is the only write target while scanning, so a full
  // pending register is exactly the "not ready" condition.
  assign wr.wr_ready = ~pending_vld_q;
  assign w_xfer      = wr.wr_valid & ~pending_vld_q;

  assign w_nib = active_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_DIM_EN
  // Offset into DRIVE phase, reduced mod 16 by the 4-bit cast.
  logic [3:0] w_drive_ofs;
  assign w_drive_ofs = 4'(32'(slot_cnt_q) - BLANK_CYCLES);
  assign w_dim_on    = (w_drive_ofs <= dim);
`else
  assign w_dim_on    = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Scheduler next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    slot_cnt_d    = slot_cnt_q;
    active_d      = active_q;
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    frame_done_d  = 1'b0;

    if (state_q == ST_IDLE) begin
      // Parked: flush anything left pending, otherwise writes go straight to
      // active. Both cannot happen at once since ready is low while pending.
      if (pending_vld_q) begin
        active_d      = pending_q;
        pending_vld_d = 1'b0;
      end else if (w_xfer) begin
        active_d = wr.wr_data;
      end
      if (en) begin
        state_d    = ST_BLANK;
        idx_d      = '0;
        slot_cnt_d = '0;
      end
    end else begin
      if (w_xfer) begin
        pending_d     = wr.wr_data;
        pending_vld_d = 1'b1;
      end

      if (!en) begin
        state_d    = ST_IDLE;
        idx_d      = '0;
        slot_cnt_d = '0;
      end else if (state_q == ST_BLANK) begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (slot_cnt_q == C_BLANK_LAST) begin
          state_d = ST_DRIVE;
        end
      end else if (state_q == ST_DRIVE) begin
        if (slot_cnt_q == C_SLOT_LAST) begin
          slot_cnt_d = '0;
          state_d    = ST_BLANK;
          if (idx_q == C_IDX_LAST) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            // Frame boundary: the only point new content becomes visible.
            if (pending_vld_q) begin
              active_d      = pending_q;
              pending_vld_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end else begin
        state_d    = ST_IDLE;
        idx_d      = '0;
        slot_cnt_d = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pin drive (registered). Gated by en so the display goes dark on the same
  // edge that parks the scanner.
  // --------------------------------------------------------------------------
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (en && (state_q == ST_DRIVE)) begin
      seg_d = f_decode(w_nib);
      if (w_dim_on) begin
        an_d[idx_q] = ~digit_mask[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      slot_cnt_q    <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slot_cnt_q    <= slot_cnt_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl (NUM_DIGITS=8, SCAN_DIV=8,
//             BLANK_CYCLES=2). Expected pin values come from a time-based
//             reference: once scanning starts, cycle t maps to digit
//             (t / SCAN_DIV) mod NUM_DIGITS and slot position t mod SCAN_DIV.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS   = 8;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic [NUM_DIGITS-1:0] digit_mask = '1;
  logic [NUM_DIGITS-1:0] AN;
  logic [6:0]            SEG;
  logic                  frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]            dim = 4'hF;
`endif

  seg_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) wr_if ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr        (wr_if),
    .digit_mask(digit_mask),
`ifdef SEG_SCAN_DIM_EN
    .dim       (dim),
`endif
    .AN        (AN),
    .SEG       (SEG),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_scan = 1'b0;   // scanning (not parked)
  int          m_t    = 0;      // cycles since scanning started
  logic [31:0] m_act  = '0;
  logic [31:0] m_pend = '0;
  bit          m_pv   = 1'b0;

  task automatic model_reset();
    m_scan = 1'b0;
    m_t    = 0;
    m_act  = '0;
    m_pend = '0;
    m_pv   = 1'b0;
  endtask

  // One clock: predict pins from pre-edge model state, advance model, compare.
  task automatic step();
    int               pos, d;
    logic [7:0]       ean;
    logic [6:0]       eseg;
    logic             efd, hs, fend;
    logic [3:0]       nib;
    @(posedge clk);
    pos  = m_t % SCAN_DIV;
    d    = (m_t / SCAN_DIV) % NUM_DIGITS;
    ean  = '1;
    eseg = 7'h7F;
    efd  = 1'b0;
    fend = m_scan && en && (pos == SCAN_DIV - 1) && (d == NUM_DIGITS - 1);
    if (m_scan && en && pos >= BLANK_CYCLES) begin
      nib  = m_act[4*d +: 4];
      eseg = SEG_TBL[nib];
`ifdef SEG_SCAN_DIM_EN
      if (((pos - BLANK_CYCLES) % 16) <= int'(dim)) ean[d] = ~digit_mask[d];
`else
      ean[d] = ~digit_mask[d];
`endif
    end
    if (fend) efd = 1'b1;
    hs = wr_if.wr_valid && !m_pv;

    if (!m_scan) begin
      if (m_pv) begin
        m_act = m_pend;
        m_pv  = 1'b0;
      end else if (hs) begin
        m_act = wr_if.wr_data;
      end
      if (en) begin
        m_scan = 1'b1;
        m_t    = 0;
      end
    end else begin
      if (fend && m_pv) begin
        m_act = m_pend;
        m_pv  = 1'b0;
      end
      if (hs) begin
        m_pend = wr_if.wr_data;
        m_pv   = 1'b1;
      end
      if (!en) begin
        m_scan = 1'b0;
        m_t    = 0;
      end else begin
        m_t = m_t + 1;
      end
    end

    #1;
    check_val("AN", 32'(AN), 32'(ean));
    check_val("SEG", 32'(SEG), 32'(eseg));
    check_val("frame_done", 32'(frame_done), 32'(efd));
    check_val("wr_ready", 32'(wr_if.wr_ready), 32'(!m_pv));
    if (hs) wr_if.wr_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;

    // Reset values while rst_n is held low
    #12;
    check_val("rst_AN", 32'(AN), 32'hFF);
    check_val("rst_SEG", 32'(SEG), 32'h7F);
    check_val("rst_ready", 32'(wr_if.wr_ready), 32'h1);
    check_val("rst_fd", 32'(frame_done), 32'h0);
    #1 rst_n = 1'b1;

    // Load contents while parked, then scan a couple of frames
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 32'h7654_3210;
    en             = 1'b1;
    run(140);

    // Mid-frame write: must wait for the frame boundary
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 32'h8888_8888;
    run(150);

    // Mask digit 2
    digit_mask = 8'hFB;
    run(80);
    digit_mask = 8'hFF;

    // Park mid-DRIVE at digit 5, then re-enable
    guard = 0;
    while (!(m_scan && ((m_t / SCAN_DIV) % NUM_DIGITS == 5) && (m_t % SCAN_DIV == 4)) && guard < 200) begin
      step();
      guard++;
    end
    check_val("reach_idx5", 32'(guard < 200), 32'h1);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(80);

    // Write left pending, then async reset mid-DRIVE discards it
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 32'hFEDC_BA98;
    guard = 0;
    while (!(m_pv && (m_t % SCAN_DIV == 4)) && guard < 200) begin
      step();
      guard++;
    end
    check_val("reach_pend", 32'(guard < 200), 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("arst_AN", 32'(AN), 32'hFF);
    check_val("arst_SEG", 32'(SEG), 32'h7F);
    check_val("arst_ready", 32'(wr_if.wr_ready), 32'h1);
    check_val("arst_fd", 32'(frame_done), 32'h0);
    model_reset();
    wr_if.wr_valid = 1'b0;
    #1 rst_n = 1'b1;
    run(80);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (!wr_if.wr_valid && $urandom_range(0, 29) == 0) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = $urandom;
      end
      if (en && $urandom_range(0, 199) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 99) == 0) digit_mask = 8'($urandom);
`ifdef SEG_SCAN_DIM_EN
      if ($urandom_range(0, 99) == 0) dim = 4'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
